// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO front-end for a DualPort_SRAM, with a 2-entry output
// buffer that hides the 1-cycle registered read. Define SRAM_FIFO_HWM_EN to add the hwm port.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 48,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic [ADDR_WIDTH-1:0] sram_wraddress,
  output logic                  sram_wren,
  output logic [ADDR_WIDTH-1:0] sram_rdaddress,
  input  logic [DATA_WIDTH-1:0] sram_q,
`ifdef SRAM_FIFO_HWM_EN
  output logic [ADDR_WIDTH+1:0] count,
  output logic [ADDR_WIDTH+1:0] hwm
`else
  output logic [ADDR_WIDTH+1:0] count
`endif
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = ADDR_WIDTH + 2;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr_nxt;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [PW-1:0]         sram_cnt;
  logic [PW-1:0]         sram_cnt_nxt;
  logic                  rd_pend;
  logic                  rd_issue;
  logic                  push;
  logic                  pop;
  logic [1:0]            buf_cnt;
  logic [1:0]            buf_cnt_nxt;
  logic                  head;
  logic                  tail;
  logic [2:0]            credit;
  logic [CW-1:0]         count_nxt;
  logic [DATA_WIDTH-1:0] buf_mem [2];

  assign sram_cnt       = wr_ptr - rd_ptr;
  assign in_ready       = !reset && (sram_cnt != DEPTH);
  assign push           = in_valid && in_ready;
  assign sram_wren      = push;
  assign sram_wraddress = wr_ptr[ADDR_WIDTH-1:0];
  assign sram_data      = in_data;
  assign sram_rdaddress = rd_ptr[ADDR_WIDTH-1:0];

  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = buf_mem[head];
  assign pop       = out_valid && out_ready;

  // A read is only issued if its word is guaranteed a buffer slot when it lands.
  assign credit   = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign rd_issue = (sram_cnt != '0) && (credit < 3'd2);
  assign tail     = head ^ buf_cnt[0];

  always_comb begin
    wr_ptr_nxt   = wr_ptr + PW'(push);
    rd_ptr_nxt   = rd_ptr + PW'(rd_issue);
    buf_cnt_nxt  = buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
    sram_cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;
    count_nxt    = {1'b0, sram_cnt_nxt} + CW'(rd_issue) + CW'(buf_cnt_nxt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_pend <= 1'b0;
      buf_cnt <= 2'd0;
      head    <= 1'b0;
      count   <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      rd_pend <= rd_issue;
      buf_cnt <= buf_cnt_nxt;
      head    <= head ^ pop;
      count   <= count_nxt;
    end
  end

  // Buffer storage needs no reset; buf_cnt alone says which slots are live.
  always_ff @(posedge clock) begin
    if (rd_pend) begin
      buf_mem[tail] <= sram_q;
    end
  end

`ifdef SRAM_FIFO_HWM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hwm <= '0;
    end else if (count > hwm) begin
      hwm <= count;
    end
  end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: vector table, hand-written corner sequences and randomized traffic
// for sram_fifo_ctrl (AW=2) against a queue-based FIFO reference and a behavioural SRAM.
module tb_sram_fifo_ctrl;

  localparam int DW = 48;
  localparam int AW = 2;
  localparam int D  = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sram_data;
  logic [AW-1:0] sram_wraddress;
  logic          sram_wren;
  logic [AW-1:0] sram_rdaddress;
  logic [DW-1:0] sram_q;
  logic [AW+1:0] count;
`ifdef SRAM_FIFO_HWM_EN
  logic [AW+1:0] hwm;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int n_push = 0;
  int n_pop  = 0;
  logic [DW-1:0] model_q [$];
  logic [DW-1:0] sram_mem [D];

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .sram_data      (sram_data),
    .sram_wraddress (sram_wraddress),
    .sram_wren      (sram_wren),
    .sram_rdaddress (sram_rdaddress),
    .sram_q         (sram_q),
`ifdef SRAM_FIFO_HWM_EN
    .count          (count),
    .hwm            (hwm)
`else
    .count          (count)
`endif
  );

  always #5 clock = ~clock;

  // Dual-port SRAM with registered read and old-data read-during-write.
  always @(posedge clock) begin
    if (sram_wren) sram_mem[sram_wraddress] <= sram_data;
    sram_q <= sram_mem[sram_rdaddress];
  end

  typedef struct {
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          exp_in_ready;
    logic          exp_wren;
    logic          exp_out_valid;
    logic [DW-1:0] exp_out_data;
    logic [AW+1:0] exp_count;
    logic          chk_addr;
    logic [AW-1:0] exp_wraddr;
    logic [AW-1:0] exp_rdaddr;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mkVec(input logic v, input logic [DW-1:0] d, input logic r,
                                 input logic ir, input logic we, input logic ov,
                                 input logic [DW-1:0] od, input logic [AW+1:0] c,
                                 input logic ca, input logic [AW-1:0] wa,
                                 input logic [AW-1:0] ra);
    vec_t t;
    t.in_valid = v;  t.in_data = d;  t.out_ready = r;
    t.exp_in_ready = ir;  t.exp_wren = we;  t.exp_out_valid = ov;
    t.exp_out_data = od;  t.exp_count = c;
    t.chk_addr = ca;  t.exp_wraddr = wa;  t.exp_rdaddr = ra;
    return t;
  endfunction

  function automatic logic [DW-1:0] rndWord();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  // Called at the negedge: compare against the queue model, advance it, move to posedge+1.
  task automatic finishCycle();
    int sz;
    sz = model_q.size();
    checkOutput("count", 64'(count), 64'(sz));
    checkOutput("in_ready_bound", 64'(in_ready ? (sz < D + 2) : (sz >= D)), 64'(1));
    checkOutput("wren", 64'(sram_wren), 64'(in_valid && in_ready));
    if (out_valid) begin
      if (sz == 0) begin
        n_vec++;
        n_fail++;
        $display("[TB] FAIL head: out_valid=1 but model holds 0 words");
      end else begin
        checkOutput("head", 64'(out_data), 64'(model_q[0]));
      end
    end
    if (out_valid && out_ready && sz > 0) begin
      void'(model_q.pop_front());
      n_pop++;
    end
    if (in_valid && in_ready) begin
      model_q.push_back(in_data);
      n_push++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b1, 48'h0, 1'b1);
    #1;
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_count", 64'(count), 64'(0));
    checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
    checkOutput("rst_wren", 64'(sram_wren), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 48'h0, 1'b0);
    model_q.delete();
`ifdef SRAM_FIFO_HWM_EN
    checkOutput("rst_hwm", 64'(hwm), 64'(0));
`endif
  endtask

  task automatic drain();
    int k;
    applyStimulus(1'b0, 48'h0, 1'b1);
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (model_q.size() == 0) break;
      finishCycle();
    end
    if (k == 50) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: %0d words left, required 0", model_q.size());
    end
    checkOutput("drain_count", 64'(count), 64'(0));
    checkOutput("drain_out_valid", 64'(out_valid), 64'(0));
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pops;
    int start_push;
    int cyc;
    bit seen;

    // Single word latency, then fill to capacity with the consumer stalled and drain.
    vecs[0]  = mkVec(1, 48'hA1, 1, 1, 1, 0, 48'h0,  0, 1, 0, 0);
    vecs[1]  = mkVec(0, 48'h0,  1, 1, 0, 0, 48'h0,  1, 1, 1, 0);
    vecs[2]  = mkVec(0, 48'h0,  1, 1, 0, 0, 48'h0,  1, 1, 1, 1);
    vecs[3]  = mkVec(0, 48'h0,  1, 1, 0, 1, 48'hA1, 1, 0, 0, 0);
    vecs[4]  = mkVec(0, 48'h0,  1, 1, 0, 0, 48'h0,  0, 0, 0, 0);
    vecs[5]  = mkVec(1, 48'h0,  0, 1, 1, 0, 48'h0,  0, 0, 0, 0);
    vecs[6]  = mkVec(1, 48'h1,  0, 1, 1, 0, 48'h0,  1, 0, 0, 0);
    vecs[7]  = mkVec(1, 48'h2,  0, 1, 1, 0, 48'h0,  2, 0, 0, 0);
    vecs[8]  = mkVec(1, 48'h3,  0, 1, 1, 1, 48'h0,  3, 0, 0, 0);
    vecs[9]  = mkVec(1, 48'h4,  0, 1, 1, 1, 48'h0,  4, 0, 0, 0);
    vecs[10] = mkVec(1, 48'h5,  0, 1, 1, 1, 48'h0,  5, 0, 0, 0);
    vecs[11] = mkVec(1, 48'h6,  0, 0, 0, 1, 48'h0,  6, 0, 0, 0);
    vecs[12] = mkVec(1, 48'h6,  0, 0, 0, 1, 48'h0,  6, 0, 0, 0);
    vecs[13] = mkVec(0, 48'h0,  1, 0, 0, 1, 48'h0,  6, 0, 0, 0);
    vecs[14] = mkVec(0, 48'h0,  1, 1, 0, 1, 48'h1,  5, 0, 0, 0);
    vecs[15] = mkVec(0, 48'h0,  1, 1, 0, 1, 48'h2,  4, 0, 0, 0);
    vecs[16] = mkVec(0, 48'h0,  1, 1, 0, 1, 48'h3,  3, 0, 0, 0);
    vecs[17] = mkVec(0, 48'h0,  1, 1, 0, 1, 48'h4,  2, 0, 0, 0);
    vecs[18] = mkVec(0, 48'h0,  1, 1, 0, 1, 48'h5,  1, 0, 0, 0);
    vecs[19] = mkVec(0, 48'h0,  1, 1, 0, 0, 48'h0,  0, 0, 0, 0);

    doReset();

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].in_data, vecs[i].out_ready);
      @(negedge clock);
      checkOutput($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
      checkOutput($sformatf("v%0d_wren", i), 64'(sram_wren), 64'(vecs[i].exp_wren));
      checkOutput($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
      checkOutput($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      if (vecs[i].exp_out_valid)
        checkOutput($sformatf("v%0d_out_data", i), 64'(out_data), 64'(vecs[i].exp_out_data));
      if (vecs[i].chk_addr) begin
        checkOutput($sformatf("v%0d_wraddr", i), 64'(sram_wraddress), 64'(vecs[i].exp_wraddr));
        checkOutput($sformatf("v%0d_rdaddr", i), 64'(sram_rdaddress), 64'(vecs[i].exp_rdaddr));
      end
      finishCycle();
    end
`ifdef SRAM_FIFO_HWM_EN
    checkOutput("hwm_after_fill", 64'(hwm), 64'(6));
`endif

    // Streaming with both sides always ready must sustain one word per cycle.
    pops = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, rndWord(), 1'b1);
      @(negedge clock);
      if (i >= 20 && out_valid) pops++;
      finishCycle();
    end
    checkOutput("throughput", 64'(pops), 64'(280));
    drain();

    // Random traffic: alternating out_ready first, then bursty fill/drain phases.
    start_push = n_push;
    for (cyc = 0; cyc < 8000 && (n_push - start_push) < 1000; cyc++) begin
      if (cyc < 200)
        applyStimulus($urandom_range(0, 3) != 0, rndWord(), (cyc % 2) == 0);
      else if (((cyc / 64) % 3) == 0)
        applyStimulus($urandom_range(0, 3) != 0, rndWord(), $urandom_range(0, 7) == 0);
      else
        applyStimulus($urandom_range(0, 3) != 0, rndWord(), $urandom_range(0, 1) == 1);
      @(negedge clock);
      finishCycle();
    end
    checkOutput("random_pushes_done", 64'((n_push - start_push) >= 1000), 64'(1));
    drain();
    checkOutput("push_pop_balance", 64'(n_pop), 64'(n_push));

    // Reset with a read in flight: state clears at once, no stale word after release.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 48'h100 + 48'(i), 1'b0);
      @(negedge clock);
      finishCycle();
    end
    checkOutput("t5_pre_valid", 64'(out_valid), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_out_valid", 64'(out_valid), 64'(0));
    checkOutput("t5_count", 64'(count), 64'(0));
    checkOutput("t5_in_ready", 64'(in_ready), 64'(0));
    model_q.delete();
    applyStimulus(1'b0, 48'h0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
`ifdef SRAM_FIFO_HWM_EN
    checkOutput("t5_hwm", 64'(hwm), 64'(0));
`endif
    applyStimulus(1'b1, 48'h55, 1'b0);
    @(negedge clock);
    finishCycle();
    applyStimulus(1'b0, 48'h0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clock);
      if (out_valid) begin
        seen = 1'b1;
        checkOutput("t5_first_word", 64'(out_data), 64'(48'h55));
      end
      finishCycle();
    end
    checkOutput("t5_first_seen", 64'(seen), 64'(1));
    drain();

`ifdef SRAM_FIFO_HWM_EN
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, rndWord(), 1'b0);
      @(negedge clock);
      finishCycle();
    end
    applyStimulus(1'b0, 48'h0, 1'b0);
    @(negedge clock);
    finishCycle();
    checkOutput("hwm_at_5", 64'(hwm), 64'(5));
    drain();
    checkOutput("hwm_held", 64'(hwm), 64'(5));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
